// File: rtl/dx_iobuf_sync.sv
// Per-bit bidirectional pad buffer: tri-state driver with optional output register
// and an optional input shift path from the pad back to dio_o.

module dx_iobuf_sync_lane #(
  parameter bit OUT_REG   = 1'b0,
  parameter int IN_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  input  logic t_i,
  input  logic pad_i,
  output logic d_o,
  output logic t_o,
  output logic q_o
);
  // With no register stages clk/rst are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  generate
    if (OUT_REG) begin : g_oreg
      logic d_q, d_d;
      logic t_q, t_d;
      assign d_d = d_i;
      assign t_d = t_i;
      // Data and enable share one edge so direction and data never skew.
      always_ff @(posedge clk) begin
        if (!rst) begin
          t_q <= 1'b1;
          d_q <= 1'b0;
        end else begin
          t_q <= t_d;
          d_q <= d_d;
        end
      end
      assign d_o = d_q;
      assign t_o = t_q;
    end else begin : g_ocomb
      assign d_o = d_i;
      assign t_o = t_i;
    end

    if (IN_STAGES == 0) begin : g_icomb
      assign q_o = pad_i;
    end else begin : g_ireg
      logic [IN_STAGES-1:0] sh_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          sh_q <= '0;
        end else begin
          sh_q[0] <= pad_i;
          for (int k = 1; k < IN_STAGES; k++) sh_q[k] <= sh_q[k-1];
        end
      end
      assign q_o = sh_q[IN_STAGES-1];
    end
  endgenerate
endmodule

module dx_iobuf_sync #(
  parameter int DATA_WIDTH = 8,
  parameter bit OUT_REG    = 1'b0,
  parameter int IN_STAGES  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dio_i,
  input  logic [DATA_WIDTH-1:0] dio_t,
  output logic [DATA_WIDTH-1:0] dio_o,
  inout  wire  [DATA_WIDTH-1:0] dio_p
);
  generate
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("dx_iobuf_sync: DATA_WIDTH must be >= 1");
    end
    if (IN_STAGES < 0 || IN_STAGES > 4) begin : g_bad_stages
      $error("dx_iobuf_sync: IN_STAGES must be in 0..4");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] i_eff;
  logic [DATA_WIDTH-1:0] t_eff;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    dx_iobuf_sync_lane #(
      .OUT_REG   (OUT_REG),
      .IN_STAGES (IN_STAGES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .d_i   (dio_i[g]),
      .t_i   (dio_t[g]),
      .pad_i (dio_p[g]),
      .d_o   (i_eff[g]),
      .t_o   (t_eff[g]),
      .q_o   (dio_o[g])
    );
    // Only a clean 0 drives; x/z on the enable releases the pad.
    assign dio_p[g] = (t_eff[g] === 1'b0) ? i_eff[g] : 1'bz;
  end
endmodule

// File: tb/tb_dx_iobuf_sync.sv
// Bench for dx_iobuf_sync: combinational, OUT_REG=1 and IN_STAGES=2 instances side by side.

module tb_dx_iobuf_sync;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rst;
    logic [7:0] t;
    logic [7:0] i;
    logic [7:0] ext;
    logic [7:0] exp;
  } vec_t;

  logic       rst0, rst1, rst2;
  logic [7:0] t0, i0, ext0, t1, i1, t2, i2, ext2;
  logic [7:0] o0, o1, o2;
  wire  [7:0] pad0, pad1, pad2;

  for (genvar b = 0; b < 8; b++) begin : g_pad
    assign pad0[b] = t0[b] ? ext0[b] : 1'bz;
    pullup (pad1[b]);
  end
  assign pad2 = ext2;

  dx_iobuf_sync #(.DATA_WIDTH(8)) u0 (
    .clk(clk), .rst(rst0), .dio_i(i0), .dio_t(t0), .dio_o(o0), .dio_p(pad0));
  dx_iobuf_sync #(.DATA_WIDTH(8), .OUT_REG(1'b1)) u1 (
    .clk(clk), .rst(rst1), .dio_i(i1), .dio_t(t1), .dio_o(o1), .dio_p(pad1));
  dx_iobuf_sync #(.DATA_WIDTH(8), .IN_STAGES(2)) u2 (
    .clk(clk), .rst(rst2), .dio_i(i2), .dio_t(t2), .dio_o(o2), .dio_p(pad2));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[8];
    logic [7:0] q0[$];
    logic [7:0] q2[$];
    logic [7:0] e;

    rst0 = 1'b1; t0 = 8'hFF; i0 = 8'h00; ext0 = 8'h00;
    rst1 = 1'b0; t1 = 8'h00; i1 = 8'hFF;
    rst2 = 1'b1; t2 = 8'hFF; i2 = 8'h00; ext2 = 8'h00;

    tbl[0] = '{rst:1'b1, t:8'hFF, i:8'h00, ext:8'hA5, exp:8'hA5};
    tbl[1] = '{rst:1'b1, t:8'h00, i:8'h3C, ext:8'hFF, exp:8'h3C};
    tbl[2] = '{rst:1'b1, t:8'h0F, i:8'h50, ext:8'h0A, exp:8'h5A};
    tbl[3] = '{rst:1'b1, t:8'hF0, i:8'h0C, ext:8'h90, exp:8'h9C};
    tbl[4] = '{rst:1'b1, t:8'hAA, i:8'h55, ext:8'hAA, exp:8'hFF};
    tbl[5] = '{rst:1'b0, t:8'h00, i:8'hC3, ext:8'h00, exp:8'hC3};
    tbl[6] = '{rst:1'b0, t:8'hFF, i:8'h00, ext:8'h69, exp:8'h69};
    tbl[7] = '{rst:1'b1, t:8'h55, i:8'h00, ext:8'h00, exp:8'h00};

    // OUT_REG=1: reset held with the inputs asking to drive, pad must stay released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("or_rst_pad", pad1, 8'hFF);
    chk("or_rst_o", o1, 8'hFF);
    @(posedge clk); #1 rst1 = 1'b1; t1 = 8'h00; i1 = 8'hC3;
    @(negedge clk); chk("or_lat0", pad1, 8'hFF);
    @(posedge clk); @(negedge clk);
    chk("or_lat1", pad1, 8'hC3);
    chk("or_loop", o1, 8'hC3);
    @(posedge clk); #1 i1 = 8'h3C;
    @(negedge clk); chk("or_hold", pad1, 8'hC3);
    @(posedge clk); @(negedge clk); chk("or_data", pad1, 8'h3C);
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk); chk("or_rst_pre", pad1, 8'h3C);
    @(posedge clk); @(negedge clk); chk("or_rst_rel", pad1, 8'hFF);
    @(posedge clk); @(negedge clk); chk("or_rst_held", pad1, 8'hFF);
    @(posedge clk); #1 rst1 = 1'b1; i1 = 8'hA5; t1 = 8'h00;
    @(negedge clk); chk("or_rst_exit", pad1, 8'hFF);
    @(posedge clk); @(negedge clk); chk("or_drive2", pad1, 8'hA5);
    @(posedge clk); #1 t1 = 8'hFF;
    @(negedge clk); chk("or_turn_pre", pad1, 8'hA5);
    @(posedge clk); @(negedge clk); chk("or_turn", pad1, 8'hFF);

    // Combinational instance: directed table.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rst0 = tbl[k].rst; t0 = tbl[k].t; i0 = tbl[k].i; ext0 = tbl[k].ext;
      @(negedge clk);
      chk($sformatf("tbl%0d_pad", k), pad0, tbl[k].exp);
      chk($sformatf("tbl%0d_o", k), o0, tbl[k].exp);
    end

    // Combinational instance: random direction/data/external drive.
    rst0 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      t0 = 8'($urandom); i0 = 8'($urandom); ext0 = 8'($urandom);
      q0.push_back((t0 & ext0) | (~t0 & i0));
      @(negedge clk);
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb0_empty: got empty queue want entry");
      end else begin
        e = q0.pop_front();
        chk("rnd_pad", pad0, e);
        chk("rnd_o", o0, e);
      end
    end

    // IN_STAGES=2: step response and reset.
    @(posedge clk); #1 ext2 = 8'hFF;
    @(negedge clk); chk("is_step0", o2, 8'h00);
    @(posedge clk); @(negedge clk); chk("is_step1", o2, 8'h00);
    @(posedge clk); @(negedge clk); chk("is_step2", o2, 8'hFF);
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk); chk("is_rst_pre", o2, 8'hFF);
    @(posedge clk); @(negedge clk); chk("is_rst", o2, 8'h00);
    @(posedge clk); @(negedge clk); chk("is_rst_held", o2, 8'h00);

    // IN_STAGES=2: random pad values, each expected two edges after it is driven.
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      rst2 = 1'b1;
      if (j < 30) begin
        ext2 = 8'($urandom);
        q2.push_back(ext2);
      end
      @(negedge clk);
      if (j >= 2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb2_empty: got empty queue want entry");
        end else begin
          e = q2.pop_front();
          chk("is_sb", o2, e);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
